// File: rtl/seq_multiplier_x16.sv
// Shift-and-add unsigned multiplier: one multiplier bit per cycle, WIDTH cycles per product.
// Optional macro SEQ_MUL_EARLY_EXIT_EN ends the run once the remaining multiplier bits are all zero.
module seq_multiplier_x16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   p_q, p_d;

  logic [WIDTH-1:0]     mplier_shift;
  logic [2*WIDTH-1:0]   acc_sum;
  logic                 last;

  assign mplier_shift = mplier_q >> 1;
  assign acc_sum      = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef SEQ_MUL_EARLY_EXIT_EN
  // No set bits left to consume: the accumulator already holds the product.
  assign last = (count_q == LastCount) || (mplier_shift == '0);
`else
  assign last = (count_q == LastCount);
`endif

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    p_d      = p_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          acc_d    = '0;
          count_d  = '0;
          state_d  = StRun;
        end else begin
          state_d  = StIdle;
        end
      end
      StRun: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_shift;
        count_d  = count_q + CW'(1);
        if (last) begin
          p_d     = acc_sum;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      p_q      <= p_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign p    = p_q;

endmodule

// File: doc/seq_multiplier_x16.md
SEQ_MULTIPLIER_X16 -- requirements
Module: seq_multiplier_x16

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand width in bits; the product is 2*WIDTH bits.
REQ-002 clk  input  1  single clock for the block; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request to multiply a by b; sampled on the rising edge.
REQ-005 a  input  WIDTH  multiplicand, unsigned.
REQ-006 b  input  WIDTH  multiplier, unsigned.
REQ-007 busy  output  1  high while an operation is in progress (RUN state).
REQ-008 done  output  1  one-cycle pulse: p holds a new result.
REQ-009 p  output  2*WIDTH  registered product a*b.

Function
REQ-010 The block SHALL implement three states: IDLE, RUN and DONE.
REQ-011 In IDLE or DONE, start=1 SHALL latch a into a 2*WIDTH multiplicand register (zero-extended), latch b into the multiplier register, clear the accumulator and count, and enter RUN.
REQ-012 In RUN, start SHALL be ignored, and a/b changes SHALL have no effect on the result.
REQ-013 Each RUN cycle SHALL add the multiplicand to the accumulator if multiplier bit 0 is 1, shift the multiplicand left by 1, shift the multiplier right by 1 and increment count.
REQ-014 Accumulator addition SHALL be 2*WIDTH bits modulo 2^(2*WIDTH); no overflow is possible for unsigned operands.
REQ-015 RUN SHALL end after the cycle with count==WIDTH-1, giving exactly WIDTH RUN cycles.
REQ-016 On leaving RUN, the final accumulator value SHALL be loaded into p, and the state SHALL become DONE for exactly one cycle with done=1.
REQ-017 p SHALL hold its value until the next completion.
REQ-018 With start=0, DONE SHALL return to IDLE; with start=1, DONE SHALL re-enter RUN (back-to-back, no idle cycle).
REQ-019 Latency: with start accepted at edge N, done=1 and p valid SHALL appear after edge N+WIDTH (REQ-027 overrides).
REQ-020 busy SHALL equal (state==RUN); done SHALL equal (state==DONE); busy and done SHALL never be high together.
REQ-021 start held high continuously SHALL produce a new operation every WIDTH+1 cycles.

Reset
REQ-022 rst_n=0 SHALL asynchronously force state=IDLE, busy=0, done=0, p=0, and clear the accumulator, multiplicand, multiplier and count.
REQ-023 Reset during RUN or DONE SHALL abort the operation: no done pulse, and p=0.
REQ-024 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Configuration
REQ-025 The block SHALL support the macro SEQ_MUL_EARLY_EXIT_EN.
REQ-026 Without SEQ_MUL_EARLY_EXIT_EN, every operation SHALL take exactly WIDTH RUN cycles.
REQ-027 With SEQ_MUL_EARLY_EXIT_EN defined, RUN SHALL also end after any cycle in which the shifted multiplier becomes 0.
REQ-028 With SEQ_MUL_EARLY_EXIT_EN defined, RUN length SHALL be max(1, index of the highest set bit of b + 1) cycles; results SHALL be identical to the non-early-exit build.

Verification
REQ-029 Reset: assert rst_n=0 mid-RUN (a=0x1234, b=0x5678) -> busy=0, done=0, p=0 immediately and no done pulse afterwards.
REQ-030 Max operands: a=0xFFFF, b=0xFFFF, start 1 cycle -> done after 16 cycles, p=0xFFFE0001, busy high for 16 cycles.
REQ-031 Zero/identity: a=0x1234, b=0x0000 -> p=0x00000000; a=0x1234, b=0x0001 -> p=0x00001234. With EARLY_EXIT_EN, each takes 1 RUN cycle; without it, 16.
REQ-032 Ignore while busy: start a=3, b=5, then pulse start with a=7, b=7 during RUN -> p=0x0000000F, exactly one done pulse.
REQ-033 Back-to-back: start held with a=0x00FF, b=0x0100, then a=0x8000, b=0x0002 at DONE -> p=0x0000FF00 then p=0x00010000; no IDLE cycle between the operations.
REQ-034 Random: 1000 random a/b pairs under both macro settings -> p==a*b for every pair, and done pulses are exactly 1 cycle wide.
